e10_csr_bridge: RTL and testbench
=================================

# e10_csr_bridge

Converts PR-management command-register writes into single Avalon-MM read/write transactions on one of eight 10GE MAC CSR slaves, selected by a port register. Returns captured read data and sticky status to the PR-management register file. It sits directly downstream of the prmg register block, behind the MMIO path used for E10 statistics and the packet-generator controls. All MAC CSR slaves run on pClk.

## Interface
- NPORTS, 8, number of MAC CSR slaves
- TIMEOUT, 1024, max cycles a request may wait on waitrequest
- TO_DATA, 32'hFFFF_FFFF, read data returned on timeout
- pClk  in  1  clock
- pClk_rst_n  in  1  synchronous, active-low reset
- cmd_wr  in  1  one-cycle strobe; prmg reg 2 written
- cmd_data  in  32  [15:0] address, bit16 write, bit17 read
- wr_data  in  32  prmg reg 3 contents
- port_sel  in  3  prmg reg 5 contents
- status_clr  in  1  one-cycle strobe; clears sticky errors
- rd_data  out  32  last captured read data (prmg reg 4)
- busy  out  1  transaction in flight
- err_timeout / err_overrun / err_cmd  out  1 each  sticky flags
- avm_address  out  16  shared address
- avm_writedata  out  32  shared write data
- avm_write  out  NPORTS  per-port write
- avm_read  out  NPORTS  per-port read
- avm_readdata  in  NPORTS*32  per-port read data, port p at [32p+31:32p]
- avm_waitrequest  in  NPORTS  per-port waitrequest

## Operation
- States: IDLE, REQ, DONE.
- IDLE, cmd_wr=1:
  - bit16 only → latch address, wr_data and port_sel; go to REQ, write.
  - bit17 only → latch address and port_sel; go to REQ, read.
  - Both bits set → no bus activity; set err_cmd.
  - Neither bit set → no-op. This is the clearing write issued by software.
- REQ:
  - Drive avm_write[p] or avm_read[p] for the latched port only. All other ports stay 0.
  - Hold address, data and strobe stable while avm_waitrequest[p]=1.
  - Completion: first edge with strobe=1 and waitrequest[p]=0.
    - Read: capture readdata[p] into rd_data.
    - Go to DONE.
  - Timeout counter starts at 0 on REQ entry and increments each REQ cycle. At count == TIMEOUT-1 with waitrequest still 1:
    - Deassert strobe.
    - Set err_timeout.
    - Read: rd_data = TO_DATA.
    - Go to DONE.
- DONE: one cycle, strobes low; return to IDLE.
- busy = 1 in REQ and DONE.
- cmd_wr while busy=1: command dropped; err_overrun set if bit16 or bit17 is set.
- port_sel and wr_data changes after acceptance do not affect the current transaction.
- Sticky flags:
  - status_clr clears all three.
  - If status_clr and a new error occur in the same cycle, the error wins (flag stays 1).
- rd_data holds its value until the next read completes; writes do not change it.

## Timing
- Reset (pClk_rst_n=0 at an edge): state IDLE, all outputs 0, including rd_data, all flags, and all strobes.
- Reset mid-REQ drops the strobe on the next cycle. No completion; rd_data is cleared.
- cmd_wr sampled at edge N → strobe high from N+1.
- Zero-wait slave: strobe is high for exactly 1 cycle. busy is high for 2 cycles. rd_data is valid from N+2.
- W waitrequest cycles: strobe is high for W+1 cycles.
- Timeout: strobe is high for exactly TIMEOUT cycles.
- A new command is accepted no earlier than the cycle after DONE (busy=0).
- Counter width: $clog2(TIMEOUT)+1. It never wraps.

## Structure
- Package e10_csr_pkg holds:
  - State enum t_e10_csr_state.
  - CMD_WR_BIT=16, CMD_RD_BIT=17.
  - Default TO_DATA.
- Sub-module e10_csr_port_mux: combinational selection of readdata/waitrequest by latched port, and one-hot strobe decode.

## Test plan
- Write, port 0, cmd 0x1_3C00, wr_data 10, waitrequest high 3 cycles → avm_write[0] high 4 cycles, addr 0x3C00, data 10; no other strobes; no flags.
- Read, port 5, cmd 0x2_1C02, readdata[5]=0x1234_5678, zero wait → avm_read[5] 1 cycle; rd_data=0x12345678 two cycles after cmd_wr; busy high 2 cycles.
- Read, port 7, waitrequest stuck high, TIMEOUT=16 → strobe high 16 cycles; err_timeout=1; rd_data=0xFFFFFFFF; status_clr → flag 0.
- cmd_wr 0x3_0000 → no strobes; err_cmd=1. cmd_wr 0x0 → no strobes, no new flag.
- Second cmd_wr 0x1_3C03 while busy → dropped; err_overrun=1; only the first transaction appears on the bus.
- Reset asserted during REQ with waitrequest high → all strobes 0 the next cycle, busy 0, rd_data 0; a fresh read afterwards completes normally.

Source files
------------

// File: rtl/e10_csr_pkg.sv
// Shared types and constants for the E10 MAC CSR bridge.
package e10_csr_pkg;

   localparam int unsigned ADDR_W     = 16;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned PORT_W     = 3;
   localparam int unsigned CMD_WR_BIT = 16;
   localparam int unsigned CMD_RD_BIT = 17;

   localparam logic [DATA_W-1:0] TO_DATA_DEFAULT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } t_e10_csr_state;

endpackage

// File: rtl/e10_csr_port_mux.sv
// Selects readdata/waitrequest of the latched port and decodes one-hot strobes.
module e10_csr_port_mux
   import e10_csr_pkg::*;
#(
   parameter int unsigned NPORTS = 8
) (
   input  logic [PORT_W-1:0]        sel_port_i,
   input  logic [NPORTS*DATA_W-1:0] avm_readdata_i,
   input  logic [NPORTS-1:0]        avm_waitrequest_i,
   input  logic [PORT_W-1:0]        dec_port_i,
   input  logic                     dec_wr_i,
   input  logic                     dec_rd_i,
   output logic [DATA_W-1:0]        readdata_o,
   output logic                     waitrequest_o,
   output logic [NPORTS-1:0]        write_oh_o,
   output logic [NPORTS-1:0]        read_oh_o
);

   always_comb begin
      readdata_o    = '0;
      waitrequest_o = 1'b0;
      write_oh_o    = '0;
      read_oh_o     = '0;
      for (int p = 0; p < int'(NPORTS); p++) begin
         if (sel_port_i == PORT_W'(p)) begin
            readdata_o    = avm_readdata_i[DATA_W*p +: DATA_W];
            waitrequest_o = avm_waitrequest_i[p];
         end
         if (dec_port_i == PORT_W'(p)) begin
            write_oh_o[p] = dec_wr_i;
            read_oh_o[p]  = dec_rd_i;
         end
      end
   end

endmodule

// File: rtl/e10_csr_bridge.sv
// Turns prmg command-register writes into single Avalon-MM transactions on one
// of NPORTS MAC CSR slaves, with captured read data and sticky error flags.
module e10_csr_bridge
   import e10_csr_pkg::*;
#(
   parameter int unsigned       NPORTS  = 8,
   parameter int unsigned       TIMEOUT = 1024,
   parameter logic [DATA_W-1:0] TO_DATA = TO_DATA_DEFAULT
) (
   input  logic                     pClk,
   input  logic                     pClk_rst_n,
   input  logic                     cmd_wr,
   input  logic [31:0]              cmd_data,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [PORT_W-1:0]        port_sel,
   input  logic                     status_clr,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     busy,
   output logic                     err_timeout,
   output logic                     err_overrun,
   output logic                     err_cmd,
   output logic [ADDR_W-1:0]        avm_address,
   output logic [DATA_W-1:0]        avm_writedata,
   output logic [NPORTS-1:0]        avm_write,
   output logic [NPORTS-1:0]        avm_read,
   input  logic [NPORTS*DATA_W-1:0] avm_readdata,
   input  logic [NPORTS-1:0]        avm_waitrequest
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

   t_e10_csr_state state_q, state_d;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [PORT_W-1:0] port_q, port_d;
   logic              is_wr_q, is_wr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              busy_q, busy_d;
   logic              err_to_q, err_to_d;
   logic              err_ov_q, err_ov_d;
   logic              err_cmd_q, err_cmd_d;
   logic [NPORTS-1:0] wr_strb_q, wr_strb_d;
   logic [NPORTS-1:0] rd_strb_q, rd_strb_d;
   logic              strb_on_d;

   logic              cmd_wbit, cmd_rbit;
   logic              accept, req_done, req_timeout;
   logic              set_to, set_ov, set_cmd;
   logic [DATA_W-1:0] sel_readdata;
   logic              sel_waitreq;
   logic              unused_cmd_bits;

   assign cmd_wbit        = cmd_data[CMD_WR_BIT];
   assign cmd_rbit        = cmd_data[CMD_RD_BIT];
   assign unused_cmd_bits = ^cmd_data[31:CMD_RD_BIT+1];

   assign accept      = (state_q == ST_IDLE) && cmd_wr && (cmd_wbit ^ cmd_rbit);
   assign req_done    = (state_q == ST_REQ) && !sel_waitreq;
   assign req_timeout = (state_q == ST_REQ) && sel_waitreq && (cnt_q == CNT_W'(TIMEOUT - 1));

   e10_csr_port_mux #(.NPORTS(NPORTS)) u_mux (
      .sel_port_i        (port_q),
      .avm_readdata_i    (avm_readdata),
      .avm_waitrequest_i (avm_waitrequest),
      .dec_port_i        (port_d),
      .dec_wr_i          (strb_on_d & is_wr_d),
      .dec_rd_i          (strb_on_d & ~is_wr_d),
      .readdata_o        (sel_readdata),
      .waitrequest_o     (sel_waitreq),
      .write_oh_o        (wr_strb_d),
      .read_oh_o         (rd_strb_d)
   );

   // State register
   always_ff @(posedge pClk) begin
      if (!pClk_rst_n) state_q <= ST_IDLE;
      else             state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = ST_REQ;
         ST_REQ:  if (req_done || req_timeout) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      port_d    = port_q;
      is_wr_d   = is_wr_q;
      cnt_d     = cnt_q;
      rd_data_d = rd_data_q;
      strb_on_d = 1'b0;
      set_to    = 1'b0;
      set_cmd   = (state_q == ST_IDLE) && cmd_wr && cmd_wbit && cmd_rbit;
      set_ov    = (state_q != ST_IDLE) && cmd_wr && (cmd_wbit || cmd_rbit);

      if (accept) begin
         addr_d    = cmd_data[ADDR_W-1:0];
         port_d    = port_sel;
         is_wr_d   = cmd_wbit;
         cnt_d     = '0;
         strb_on_d = 1'b1;
         if (cmd_wbit) wdata_d = wr_data;
      end else if (req_done) begin
         if (!is_wr_q) rd_data_d = sel_readdata;
      end else if (req_timeout) begin
         set_to = 1'b1;
         if (!is_wr_q) rd_data_d = TO_DATA;
      end else if (state_q == ST_REQ) begin
         cnt_d     = cnt_q + CNT_W'(1);
         strb_on_d = 1'b1;
      end

      busy_d    = (state_d != ST_IDLE);
      err_to_d  = (err_to_q  && !status_clr) || set_to;
      err_ov_d  = (err_ov_q  && !status_clr) || set_ov;
      err_cmd_d = (err_cmd_q && !status_clr) || set_cmd;
   end

   always_ff @(posedge pClk) begin
      if (!pClk_rst_n) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         port_q    <= '0;
         is_wr_q   <= 1'b0;
         cnt_q     <= '0;
         rd_data_q <= '0;
         busy_q    <= 1'b0;
         err_to_q  <= 1'b0;
         err_ov_q  <= 1'b0;
         err_cmd_q <= 1'b0;
         wr_strb_q <= '0;
         rd_strb_q <= '0;
      end else begin
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         port_q    <= port_d;
         is_wr_q   <= is_wr_d;
         cnt_q     <= cnt_d;
         rd_data_q <= rd_data_d;
         busy_q    <= busy_d;
         err_to_q  <= err_to_d;
         err_ov_q  <= err_ov_d;
         err_cmd_q <= err_cmd_d;
         wr_strb_q <= wr_strb_d;
         rd_strb_q <= rd_strb_d;
      end
   end

   assign rd_data       = rd_data_q;
   assign busy          = busy_q;
   assign err_timeout   = err_to_q;
   assign err_overrun   = err_ov_q;
   assign err_cmd       = err_cmd_q;
   assign avm_address   = addr_q;
   assign avm_writedata = wdata_q;
   assign avm_write     = wr_strb_q;
   assign avm_read      = rd_strb_q;

endmodule

// File: tb/tb_e10_csr_bridge.sv
// Self-checking bench for e10_csr_bridge: directed scenarios plus randomized
// transactions against a transaction-level expectation model.
module tb_e10_csr_bridge;

   localparam int unsigned NP  = 8;
   localparam int unsigned TMO = 16;
   localparam logic [31:0] TOD = 32'hFFFF_FFFF;

   logic           pClk = 1'b0;
   logic           pClk_rst_n;
   logic           cmd_wr;
   logic [31:0]    cmd_data;
   logic [31:0]    wr_data;
   logic [2:0]     port_sel;
   logic           status_clr;
   logic [31:0]    rd_data;
   logic           busy;
   logic           err_timeout, err_overrun, err_cmd;
   logic [15:0]    avm_address;
   logic [31:0]    avm_writedata;
   logic [NP-1:0]  avm_write, avm_read;
   logic [NP*32-1:0] avm_readdata;
   logic [NP-1:0]  avm_waitrequest;

   int checks = 0;
   int errors = 0;

   // Expected architectural state
   logic [31:0] exp_rd;
   bit          exp_to, exp_ov, exp_cmd;

   e10_csr_bridge #(.NPORTS(NP), .TIMEOUT(TMO), .TO_DATA(TOD)) dut (
      .pClk            (pClk),
      .pClk_rst_n      (pClk_rst_n),
      .cmd_wr          (cmd_wr),
      .cmd_data        (cmd_data),
      .wr_data         (wr_data),
      .port_sel        (port_sel),
      .status_clr      (status_clr),
      .rd_data         (rd_data),
      .busy            (busy),
      .err_timeout     (err_timeout),
      .err_overrun     (err_overrun),
      .err_cmd         (err_cmd),
      .avm_address     (avm_address),
      .avm_writedata   (avm_writedata),
      .avm_write       (avm_write),
      .avm_read        (avm_read),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest)
   );

   always #5 pClk = ~pClk;

   task automatic tick();
      @(posedge pClk);
      #1;
   endtask

   task automatic check_state(input string tag);
      checks++;
      if (rd_data !== exp_rd) begin
         errors++;
         $display("FAIL %s rd_data: got %08h expected %08h", tag, rd_data, exp_rd);
      end
      checks++;
      if ({err_timeout, err_overrun, err_cmd} !== {exp_to, exp_ov, exp_cmd}) begin
         errors++;
         $display("FAIL %s flags(to,ov,cmd): got %03b expected %03b", tag,
                  {err_timeout, err_overrun, err_cmd}, {exp_to, exp_ov, exp_cmd});
      end
      checks++;
      if ({avm_write, avm_read, busy} !== '0) begin
         errors++;
         $display("FAIL %s idle bus: write=%02h read=%02h busy=%0b expected all 0", tag,
                  avm_write, avm_read, busy);
      end
   endtask

   // One full transaction; w = cycles of waitrequest on the target port.
   task automatic run_txn(input bit is_wr, input int unsigned port, input logic [15:0] addr,
                          input logic [31:0] data, input int unsigned w,
                          input logic [31:0] rdv, input bit ovr, input string tag);
      int unsigned hi = 0, bz = 0, exp_hi;
      logic [NP-1:0] exp_oh;
      bit to;
      to     = (w >= TMO);
      exp_hi = to ? TMO : w + 1;
      exp_oh = NP'(1) << port;
      for (int p = 0; p < int'(NP); p++) avm_readdata[32*p +: 32] = $urandom;
      avm_readdata[32*port +: 32] = rdv;
      avm_waitrequest       = NP'($urandom);
      avm_waitrequest[port] = (w > 0);
      cmd_data = {14'd0, !is_wr, is_wr, addr};
      wr_data  = data;
      port_sel = 3'(port);
      cmd_wr   = 1'b1;
      tick();
      cmd_wr   = 1'b0;
      cmd_data = $urandom;
      wr_data  = $urandom;
      port_sel = 3'($urandom);
      while (busy === 1'b1 && bz < TMO + 8) begin
         bz++;
         if ((avm_write | avm_read) != '0) begin
            hi++;
            checks++;
            if ((is_wr ? avm_write : avm_read) !== exp_oh ||
                (is_wr ? avm_read : avm_write) !== '0) begin
               errors++;
               $display("FAIL %s strobes: write=%02h read=%02h expected one-hot %02h", tag,
                        avm_write, avm_read, exp_oh);
            end
            checks++;
            if (avm_address !== addr || (is_wr && avm_writedata !== data)) begin
               errors++;
               $display("FAIL %s addr/data: got %04h/%08h expected %04h/%08h", tag,
                        avm_address, avm_writedata, addr, data);
            end
            avm_waitrequest[port] = (hi <= w);
            if (ovr && hi == 1) begin
               cmd_wr   = 1'b1;
               cmd_data = 32'h0001_3C03;
            end
         end
         tick();
         cmd_wr = 1'b0;
      end
      checks++;
      if (hi != exp_hi || bz != exp_hi + 1) begin
         errors++;
         $display("FAIL %s timing: strobe %0d busy %0d cycles, expected %0d/%0d", tag,
                  hi, bz, exp_hi, exp_hi + 1);
      end
      if (!is_wr) exp_rd = to ? TOD : rdv;
      exp_to |= to;
      exp_ov |= ovr;
      check_state(tag);
   endtask

   task automatic clear_status();
      status_clr = 1'b1;
      tick();
      status_clr = 1'b0;
      exp_to = 0; exp_ov = 0; exp_cmd = 0;
   endtask

   task automatic test_reset();
      pClk_rst_n = 1'b0;
      repeat (3) tick();
      pClk_rst_n = 1'b1;
      exp_rd = '0; exp_to = 0; exp_ov = 0; exp_cmd = 0;
      check_state("reset");
      checks++;
      if (avm_address !== '0 || avm_writedata !== '0) begin
         errors++;
         $display("FAIL reset addr/data: got %04h/%08h expected 0/0", avm_address, avm_writedata);
      end
   endtask

   task automatic test_write_wait();
      run_txn(1'b1, 0, 16'h3C00, 32'd10, 3, 32'h0, 1'b0, "write_wait");
   endtask

   task automatic test_read_zero_wait();
      run_txn(1'b0, 5, 16'h1C02, 32'h0, 0, 32'h1234_5678, 1'b0, "read_zero");
      run_txn(1'b1, 2, 16'h0044, 32'hCAFE_0001, 0, 32'h0, 1'b0, "write_keeps_rd");
   endtask

   task automatic test_timeout();
      run_txn(1'b0, 7, 16'h0100, 32'h0, TMO + 4, 32'h5555_AAAA, 1'b0, "timeout");
      run_txn(1'b0, 6, 16'h0104, 32'h0, TMO - 1, 32'h0BAD_F00D, 1'b0, "last_cycle_ok");
      clear_status();
      check_state("timeout_clr");
   endtask

   task automatic test_cmd_err();
      cmd_data = 32'h0003_0000; cmd_wr = 1'b1;
      tick();
      cmd_wr = 1'b0;
      exp_cmd = 1;
      check_state("both_bits");
      tick();
      check_state("both_bits_quiet");
      cmd_data = 32'h0000_0000; cmd_wr = 1'b1;
      tick();
      cmd_wr = 1'b0;
      check_state("noop");
      // Clear and new error in the same cycle: error wins
      cmd_data = 32'h0003_1234; cmd_wr = 1'b1; status_clr = 1'b1;
      tick();
      cmd_wr = 1'b0; status_clr = 1'b0;
      check_state("clr_collision");
      clear_status();
      check_state("cmd_clr");
   endtask

   task automatic test_overrun();
      run_txn(1'b1, 3, 16'h3C00, 32'h0000_0077, 2, 32'h0, 1'b1, "overrun");
      repeat (3) begin
         tick();
         check_state("overrun_quiet");
      end
      clear_status();
   endtask

   task automatic test_reset_mid_req();
      cmd_data = 32'h0002_0200; port_sel = 3'd4; cmd_wr = 1'b1;
      avm_waitrequest = '1;
      tick();
      cmd_wr = 1'b0;
      repeat (4) tick();
      checks++;
      if (avm_read !== 8'h10) begin
         errors++;
         $display("FAIL reset_mid pre: read=%02h expected 10", avm_read);
      end
      pClk_rst_n = 1'b0;
      tick();
      pClk_rst_n = 1'b1;
      exp_rd = '0; exp_to = 0; exp_ov = 0; exp_cmd = 0;
      check_state("reset_mid");
      run_txn(1'b0, 1, 16'h0208, 32'h0, 1, 32'hA5A5_0F0F, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         int unsigned w;
         w = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 3) : $urandom_range(0, 5);
         run_txn(1'($urandom), $urandom_range(0, NP - 1), 16'($urandom), $urandom, w,
                 $urandom, 1'b0, "random");
         if ($urandom_range(0, 3) == 0) begin
            clear_status();
            check_state("random_clr");
         end
      end
   endtask

   initial begin
      pClk_rst_n      = 1'b0;
      cmd_wr          = 1'b0;
      cmd_data        = '0;
      wr_data         = '0;
      port_sel        = '0;
      status_clr      = 1'b0;
      avm_readdata    = '0;
      avm_waitrequest = '0;
      test_reset();
      test_write_wait();
      test_read_zero_wait();
      test_timeout();
      test_cmd_err();
      test_overrun();
      test_reset_mid_req();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
